// File: rtl/wb_write_queue.sv
// Writeback queue: buffers ALU and load results in an in-order FIFO and retires
// one register-file write per cycle, exporting a per-register pending mask.
module wb_write_queue #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       alu_valid,
    input  logic [ADDR_W-1:0]          alu_reg,
    input  logic [DATA_W-1:0]          alu_data,
    output logic                       alu_ready,
    input  logic                       mem_valid,
    input  logic [ADDR_W-1:0]          mem_reg,
    input  logic [DATA_W-1:0]          mem_data,
    output logic                       mem_ready,
    input  logic                       rf_hold,
    output logic                       rf_we,
    output logic [ADDR_W-1:0]          rf_waddr,
    output logic [DATA_W-1:0]          rf_wdata,
    output logic [(1<<ADDR_W)-1:0]     pend_mask,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREG  = 1 << ADDR_W;

    logic [ADDR_W-1:0] reg_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0]  valid_reg;
    logic [PTR_W-1:0]  rd_ptr_reg, wr_ptr_reg;
    logic [CNT_W-1:0]  count_reg;

    logic              full, empty, push, pop;
    logic [ADDR_W-1:0] push_reg;
    logic [DATA_W-1:0] push_data;
    logic [NREG-1:0]   dec [DEPTH];

    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);

    // Readies are gated by rst so every output reads zero while reset is held.
    assign mem_ready = rst && !full && !flush;
    assign alu_ready = mem_ready && !mem_valid;

    assign push      = (mem_valid && mem_ready) || (alu_valid && alu_ready);
    assign push_reg  = mem_valid ? mem_reg  : alu_reg;
    assign push_data = mem_valid ? mem_data : alu_data;

    assign rf_we    = rst && !empty && !rf_hold && !flush;
    assign pop      = rf_we;
    assign rf_waddr = rf_we ? reg_mem[rd_ptr_reg]  : '0;
    assign rf_wdata = rf_we ? data_mem[rd_ptr_reg] : '0;
    assign count    = count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            valid_reg  <= '0;
        end else if (flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            valid_reg  <= '0;
        end else begin
            // Push and pop never target the same slot: that needs count 0 or DEPTH.
            if (push) begin
                wr_ptr_reg            <= wr_ptr_reg + PTR_W'(1);
                valid_reg[wr_ptr_reg] <= 1'b1;
            end
            if (pop) begin
                rd_ptr_reg            <= rd_ptr_reg + PTR_W'(1);
                valid_reg[rd_ptr_reg] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            reg_mem[wr_ptr_reg]  <= push_reg;
            data_mem[wr_ptr_reg] <= push_data;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_dec
            assign dec[gi] = valid_reg[gi] ? (NREG'(1) << reg_mem[gi]) : '0;
        end
    endgenerate

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pend_mask = pend_mask | dec[i];
        end
    end

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue: expected retirements go into a scoreboard
// queue, a negedge monitor compares every register-file write against it.
module tb_wb_write_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        alu_valid = 1'b0;
    logic [3:0]  alu_reg = '0;
    logic [15:0] alu_data = '0;
    logic        alu_ready;
    logic        mem_valid = 1'b0;
    logic [3:0]  mem_reg = '0;
    logic [15:0] mem_data = '0;
    logic        mem_ready;
    logic        rf_hold = 1'b0;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [15:0] pend_mask;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;
    logic [19:0] exp_q[$];
    logic [19:0] mon_e;

    wb_write_queue #(.DATA_W(16), .ADDR_W(4), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
        .rf_hold(rf_hold), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pend_mask(pend_mask), .count(count)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every write must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst && rf_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write", rf_waddr, rf_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if ({rf_waddr, rf_wdata} !== mon_e) begin
                    errors++;
                    $display("FAIL rf_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                             rf_waddr, rf_wdata, mon_e[19:16], mon_e[15:0]);
                end else begin
                    $display("write R%0d <= %h", rf_waddr, rf_wdata);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        repeat (12) begin
            at_neg();
            if (count == 0) break;
        end
        chk(name, 32'(count), 32'd0);
        tick();
    endtask

    task automatic alu_push(input logic [3:0] r, input logic [15:0] d);
        alu_valid = 1'b1;
        alu_reg   = r;
        alu_data  = d;
    endtask

    initial begin
        // Reset state, readies low while held
        at_neg();
        chk("reset_count", 32'(count), 0);
        chk("reset_pend", 32'(pend_mask), 0);
        chk("reset_we", {rf_we, rf_waddr, rf_wdata}, 0);
        chk("reset_mem_ready", 32'(mem_ready), 0);
        tick();
        rst = 1'b1;
        at_neg();
        chk("post_reset_readies", {alu_ready, mem_ready}, 32'b11);

        // Single load result
        tick();
        mem_valid = 1'b1; mem_reg = 4'd5; mem_data = 16'h1234;
        exp_q.push_back({4'd5, 16'h1234});
        at_neg();
        chk("t1_mem_ready", 32'(mem_ready), 1);
        tick();
        mem_valid = 1'b0;
        at_neg();
        chk("t1_we", 32'(rf_we), 1);
        chk("t1_pend", 32'(pend_mask), 32'h0020);
        chk("t1_count", 32'(count), 1);
        tick();
        at_neg();
        chk("t1_count_after", 32'(count), 0);
        chk("t1_pend_after", 32'(pend_mask), 0);
        chk("t1_idle_outputs", {rf_we, rf_waddr, rf_wdata}, 0);

        // Memory path wins over ALU
        tick();
        alu_push(4'd2, 16'h00AA);
        mem_valid = 1'b1; mem_reg = 4'd3; mem_data = 16'h00BB;
        exp_q.push_back({4'd3, 16'h00BB});
        exp_q.push_back({4'd2, 16'h00AA});
        at_neg();
        chk("t2_alu_ready_blocked", 32'(alu_ready), 0);
        chk("t2_mem_ready", 32'(mem_ready), 1);
        tick();
        mem_valid = 1'b0;
        at_neg();
        chk("t2_alu_ready", 32'(alu_ready), 1);
        tick();
        alu_valid = 1'b0;
        at_neg();
        chk("t2_count", 32'(count), 1);
        drain("t2_drain");

        // Hold: fill to four, fifth refused until a slot frees
        rf_hold = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            alu_push(4'(i), 16'h0100 + 16'(i));
            exp_q.push_back({4'(i), 16'h0100 + 16'(i)});
            at_neg();
            chk("t3_alu_ready_fill", 32'(alu_ready), 1);
            tick();
        end
        alu_push(4'd5, 16'h0105);
        exp_q.push_back({4'd5, 16'h0105});
        at_neg();
        chk("t3_alu_ready_full", 32'(alu_ready), 0);
        chk("t3_count_full", 32'(count), 4);
        chk("t3_pend", 32'(pend_mask), 32'h001E);
        chk("t3_we_held", 32'(rf_we), 0);
        tick();
        rf_hold = 1'b0;
        at_neg();
        chk("t3_ready_full_draining", 32'(alu_ready), 0);
        chk("t3_we", 32'(rf_we), 1);
        tick();
        at_neg();
        chk("t3_ready_after_pop", 32'(alu_ready), 1);
        chk("t3_count_3", 32'(count), 3);
        tick();
        alu_valid = 1'b0;
        at_neg();
        chk("t3_push_pop_count", 32'(count), 3);
        chk("t3_pend_r3r4r5", 32'(pend_mask), 32'h0038);
        drain("t3_drain");

        // Same register twice: last accepted wins, bit held until last retires
        rf_hold = 1'b1;
        alu_push(4'd7, 16'h0001);
        exp_q.push_back({4'd7, 16'h0001});
        tick();
        alu_push(4'd7, 16'h0002);
        exp_q.push_back({4'd7, 16'h0002});
        tick();
        alu_valid = 1'b0;
        at_neg();
        chk("t4_pend", 32'(pend_mask), 32'h0080);
        chk("t4_count", 32'(count), 2);
        tick();
        rf_hold = 1'b0;
        at_neg();
        chk("t4_pend_first_retire", 32'(pend_mask), 32'h0080);
        tick();
        at_neg();
        chk("t4_pend_second_retire", 32'(pend_mask), 32'h0080);
        tick();
        at_neg();
        chk("t4_pend_clear", 32'(pend_mask), 0);
        tick();

        // Flush discards queued entries; none must ever be written
        rf_hold = 1'b1;
        for (int i = 8; i <= 10; i++) begin
            alu_push(4'(i), 16'hF000 + 16'(i));
            tick();
        end
        alu_valid = 1'b0;
        at_neg();
        chk("t5_count", 32'(count), 3);
        chk("t5_pend", 32'(pend_mask), 32'h0700);
        tick();
        flush = 1'b1;
        mem_valid = 1'b1; mem_reg = 4'd9; mem_data = 16'hDEAD;
        at_neg();
        chk("t5_flush_we", 32'(rf_we), 0);
        chk("t5_flush_readies", {alu_ready, mem_ready}, 0);
        tick();
        flush = 1'b0;
        mem_valid = 1'b0;
        rf_hold = 1'b0;
        at_neg();
        chk("t5_count_after", 32'(count), 0);
        chk("t5_pend_after", 32'(pend_mask), 0);
        chk("t5_we_after", 32'(rf_we), 0);
        repeat (3) tick();

        // Asynchronous reset in the middle of draining
        rf_hold = 1'b1;
        for (int i = 11; i <= 13; i++) begin
            alu_push(4'(i), 16'hC000 + 16'(i));
            tick();
        end
        alu_valid = 1'b0;
        exp_q.push_back({4'd11, 16'hC00B});
        rf_hold = 1'b0;
        tick();
        chk("t6_count_mid", 32'(count), 2);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_async_outputs", {rf_we, rf_waddr, rf_wdata}, 0);
        chk("t6_async_count", 32'(count), 0);
        chk("t6_async_pend", 32'(pend_mask), 0);
        chk("t6_async_readies", {alu_ready, mem_ready}, 0);
        tick();
        rst = 1'b1;
        at_neg();
        chk("t6_readies_back", {alu_ready, mem_ready}, 32'b11);
        chk("t6_empty_we", 32'(rf_we), 0);
        tick();
        mem_valid = 1'b1; mem_reg = 4'd0; mem_data = 16'hBEEF;
        exp_q.push_back({4'd0, 16'hBEEF});
        tick();
        mem_valid = 1'b0;
        at_neg();
        chk("t6_pend_r0", 32'(pend_mask), 32'h0001);
        drain("t6_drain");

        repeat (2) tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
